// File: rtl/vga_tile_timing_pkg.sv
// ---------------------------------------------------------------------------
// vga_tile_timing_pkg
//
// Shared timing constants for the game display path. It holds the default
// 640x480 raster timings, the helpers that derive line/frame totals and
// counter widths, and the default sync polarity. The raster generator and
// the sprite/colour modules use these so they agree on one timing set.
//
// Contents:
//   *_DEF constants      default porch/sync/display widths and tile size
//   axis_total()         sync + back porch + display + front porch
//   count_width()        bits needed to hold 0..total
//   H_TOTAL_DEF/V_TOTAL_DEF  derived defaults (800 x 525)
//   AXIS_H/AXIS_V        indices of the horizontal/vertical tile axes
// ---------------------------------------------------------------------------
package vga_tile_timing_pkg;

  localparam int H_DISPLAY_DEF = 640;
  localparam int H_FRONT_DEF   = 18;
  localparam int H_SYNC_DEF    = 92;
  localparam int H_BACK_DEF    = 50;

  localparam int V_DISPLAY_DEF = 480;
  localparam int V_FRONT_DEF   = 10;
  localparam int V_SYNC_DEF    = 2;
  localparam int V_BACK_DEF    = 33;

  localparam int TILE_W_DEF    = 32;
  localparam int TILE_H_DEF    = 32;

  // 1: sync pulses are driven low while asserted.
  localparam bit SYNC_ACTIVE_LOW_DEF = 1'b1;

  localparam int COORD_W_DEF     = 10;
  localparam int FRAME_CNT_W_DEF = 8;

  // Total cycles (or lines) of one axis period.
  function automatic int axis_total(input int display, input int front,
                                    input int sync, input int back);
    return sync + back + display + front;
  endfunction

  // Width able to hold every value from 0 up to and including total.
  function automatic int count_width(input int total);
    return (total < 1) ? 1 : $clog2(total + 1);
  endfunction

  localparam int H_TOTAL_DEF = axis_total(H_DISPLAY_DEF, H_FRONT_DEF,
                                          H_SYNC_DEF, H_BACK_DEF);
  localparam int V_TOTAL_DEF = axis_total(V_DISPLAY_DEF, V_FRONT_DEF,
                                          V_SYNC_DEF, V_BACK_DEF);

  localparam int AXIS_H   = 0;
  localparam int AXIS_V   = 1;
  localparam int NUM_AXES = 2;

endpackage

// File: rtl/vga_tile_timing_tile_axis_counter.sv
// ---------------------------------------------------------------------------
// tile_axis_counter
//
// Pixel coordinate, tile index and offset-inside-tile for one raster axis,
// built from increments only (no multiply/divide). The internal "cur_*"
// registers hold the value the next shown position will use; the output
// registers show that value while show is high and zero otherwise.
//
// Ports:
//   clk     in   clock
//   rst     in   asynchronous active-high reset
//   clear   in   this position is the first of the axis: its value is 0
//   step    in   advance the stored value after this position
//   show    in   drive the value onto the outputs (else outputs are 0)
//   pixel   out  [COORD_W] coordinate along the axis
//   tile    out  [COORD_W] tile index
//   offset  out  [COORD_W] offset inside the current tile
// ---------------------------------------------------------------------------
module tile_axis_counter #(
  parameter int TILE    = 32,
  parameter int COORD_W = 10
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               clear,
  input  logic               step,
  input  logic               show,
  output logic [COORD_W-1:0] pixel,
  output logic [COORD_W-1:0] tile,
  output logic [COORD_W-1:0] offset
);

  localparam logic [COORD_W-1:0] OFF_LAST = COORD_W'(TILE - 1);
  localparam logic [COORD_W-1:0] ONE      = COORD_W'(1);

  logic [COORD_W-1:0] cur_pix_reg, cur_tile_reg, cur_off_reg;
  logic [COORD_W-1:0] use_pix, use_tile, use_off;
  logic [COORD_W-1:0] inc_pix, inc_tile, inc_off;

  always_comb begin
    use_pix  = clear ? '0 : cur_pix_reg;
    use_tile = clear ? '0 : cur_tile_reg;
    use_off  = clear ? '0 : cur_off_reg;

    inc_pix  = use_pix + ONE;
    inc_tile = use_tile;
    inc_off  = use_off + ONE;
    // Tile boundary: the offset folds back and the tile index moves on.
    // A partial last tile simply never reaches OFF_LAST.
    if (use_off == OFF_LAST) begin
      inc_off  = '0;
      inc_tile = use_tile + ONE;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cur_pix_reg  <= '0;
      cur_tile_reg <= '0;
      cur_off_reg  <= '0;
      pixel        <= '0;
      tile         <= '0;
      offset       <= '0;
    end else begin
      // step wins over clear: when both hit the same position the
      // increment is already taken from the cleared value.
      if (step) begin
        cur_pix_reg  <= inc_pix;
        cur_tile_reg <= inc_tile;
        cur_off_reg  <= inc_off;
      end else if (clear) begin
        cur_pix_reg  <= '0;
        cur_tile_reg <= '0;
        cur_off_reg  <= '0;
      end
      pixel  <= show ? use_pix  : '0;
      tile   <= show ? use_tile : '0;
      offset <= show ? use_off  : '0;
    end
  end

endmodule

// File: rtl/vga_tile_timing.sv
// ---------------------------------------------------------------------------
// vga_tile_timing
//
// Parametrised VGA raster generator. A horizontal and a vertical counter
// walk each line/frame in the order sync, back porch, display, front
// porch. From them it derives sync pulses, the active-video flag, pixel
// coordinates and tile-grid coordinates. Tile coordinates come from two
// tile_axis_counter instances, so no multiply/divide is needed. Every
// output is registered one cycle after the counters and all outputs are
// mutually aligned.
//
// Build option: define VGA_TILE_TIMING_FRAME_CNT_EN to add the
// FRAME_CNT_W parameter and the o_frame_count port (completed frames,
// wrapping). Without it the port and the counter do not exist.
//
// Ports:
//   i_Clk                      in   pixel clock, one pixel per cycle
//   i_Rst                      in   asynchronous active-high reset
//   o_VGA_HSync / o_VGA_VSync  out  sync pulses (polarity SYNC_ACTIVE_LOW)
//   o_active                   out  high during visible pixels
//   o_pixel_x / o_pixel_y      out  [COORD_W] visible pixel coordinate
//   o_tile_col / o_tile_row    out  [COORD_W] tile index
//   o_tile_off_x/o_tile_off_y  out  [COORD_W] offset inside the tile
//   o_line_start               out  first active pixel of each visible line
//   o_frame_end                out  cycle right after last active pixel
//   o_frame_count              out  [FRAME_CNT_W] completed frames (option)
// ---------------------------------------------------------------------------
module vga_tile_timing
  import vga_tile_timing_pkg::*;
#(
  parameter int H_DISPLAY       = H_DISPLAY_DEF,
  parameter int H_FRONT         = H_FRONT_DEF,
  parameter int H_SYNC          = H_SYNC_DEF,
  parameter int H_BACK          = H_BACK_DEF,
  parameter int V_DISPLAY       = V_DISPLAY_DEF,
  parameter int V_FRONT         = V_FRONT_DEF,
  parameter int V_SYNC          = V_SYNC_DEF,
  parameter int V_BACK          = V_BACK_DEF,
  parameter int TILE_W          = TILE_W_DEF,
  parameter int TILE_H          = TILE_H_DEF,
  parameter bit SYNC_ACTIVE_LOW = SYNC_ACTIVE_LOW_DEF,
  parameter int COORD_W         = COORD_W_DEF
`ifdef VGA_TILE_TIMING_FRAME_CNT_EN
  ,
  parameter int FRAME_CNT_W     = FRAME_CNT_W_DEF
`endif
) (
  input  logic               i_Clk,
  input  logic               i_Rst,
  output logic               o_VGA_HSync,
  output logic               o_VGA_VSync,
  output logic               o_active,
  output logic [COORD_W-1:0] o_pixel_x,
  output logic [COORD_W-1:0] o_pixel_y,
  output logic [COORD_W-1:0] o_tile_col,
  output logic [COORD_W-1:0] o_tile_row,
  output logic [COORD_W-1:0] o_tile_off_x,
  output logic [COORD_W-1:0] o_tile_off_y,
  output logic               o_line_start,
  output logic               o_frame_end
`ifdef VGA_TILE_TIMING_FRAME_CNT_EN
  ,
  output logic [FRAME_CNT_W-1:0] o_frame_count
`endif
);

  localparam int H_TOTAL = axis_total(H_DISPLAY, H_FRONT, H_SYNC, H_BACK);
  localparam int V_TOTAL = axis_total(V_DISPLAY, V_FRONT, V_SYNC, V_BACK);
  localparam int H_CW    = count_width(H_TOTAL);
  localparam int V_CW    = count_width(V_TOTAL);

  localparam logic [H_CW-1:0] H_LAST      = H_CW'(H_TOTAL - 1);
  localparam logic [H_CW-1:0] H_SYNC_END  = H_CW'(H_SYNC);
  localparam logic [H_CW-1:0] H_ACT_START = H_CW'(H_SYNC + H_BACK);
  localparam logic [H_CW-1:0] H_ACT_LAST  = H_CW'(H_SYNC + H_BACK + H_DISPLAY - 1);

  localparam logic [V_CW-1:0] V_LAST      = V_CW'(V_TOTAL - 1);
  localparam logic [V_CW-1:0] V_SYNC_END  = V_CW'(V_SYNC);
  localparam logic [V_CW-1:0] V_ACT_START = V_CW'(V_SYNC + V_BACK);
  localparam logic [V_CW-1:0] V_ACT_LAST  = V_CW'(V_SYNC + V_BACK + V_DISPLAY - 1);

  localparam logic SYNC_ON  = SYNC_ACTIVE_LOW ? 1'b0 : 1'b1;
  localparam logic SYNC_OFF = ~SYNC_ON;

  // Raster position
  logic [H_CW-1:0] h_cnt_reg, h_cnt_next;
  logic [V_CW-1:0] v_cnt_reg, v_cnt_next;

  // Position decode (combinational, for the current counter values)
  logic h_act, v_act, h_first, h_last, v_first, v_last, active;

  // Registered outputs
  logic hsync_reg, vsync_reg, active_reg, line_start_reg, frame_end_reg;
  // Last active pixel of the frame is on the outputs this cycle
  logic last_px_reg;

  // Per-axis tile counter hookup
  logic               axis_clear  [NUM_AXES];
  logic               axis_step   [NUM_AXES];
  logic [COORD_W-1:0] axis_pixel  [NUM_AXES];
  logic [COORD_W-1:0] axis_tile   [NUM_AXES];
  logic [COORD_W-1:0] axis_offset [NUM_AXES];

  always_comb begin
    h_act   = (h_cnt_reg >= H_ACT_START) && (h_cnt_reg <= H_ACT_LAST);
    v_act   = (v_cnt_reg >= V_ACT_START) && (v_cnt_reg <= V_ACT_LAST);
    h_first = (h_cnt_reg == H_ACT_START);
    h_last  = (h_cnt_reg == H_ACT_LAST);
    v_first = (v_cnt_reg == V_ACT_START);
    v_last  = (v_cnt_reg == V_ACT_LAST);
    active  = h_act && v_act;

    h_cnt_next = h_cnt_reg + H_CW'(1);
    v_cnt_next = v_cnt_reg;
    if (h_cnt_reg == H_LAST) begin
      h_cnt_next = '0;
      v_cnt_next = (v_cnt_reg == V_LAST) ? '0 : v_cnt_reg + V_CW'(1);
    end
  end

  // Horizontal axis: restart at each line's first visible pixel, advance
  // on every visible pixel.
  assign axis_clear[AXIS_H] = h_first && v_act;
  assign axis_step[AXIS_H]  = active;
  // Vertical axis: restart at the frame's first visible pixel, advance
  // once per visible line on its last visible pixel.
  assign axis_clear[AXIS_V] = h_first && v_first;
  assign axis_step[AXIS_V]  = h_last && v_act;

  genvar gi;
  generate
    for (gi = 0; gi < NUM_AXES; gi++) begin : g_axis
      tile_axis_counter #(
        .TILE    ((gi == AXIS_H) ? TILE_W : TILE_H),
        .COORD_W (COORD_W)
      ) u_axis (
        .clk    (i_Clk),
        .rst    (i_Rst),
        .clear  (axis_clear[gi]),
        .step   (axis_step[gi]),
        .show   (active),
        .pixel  (axis_pixel[gi]),
        .tile   (axis_tile[gi]),
        .offset (axis_offset[gi])
      );
    end
  endgenerate

  always_ff @(posedge i_Clk or posedge i_Rst) begin
    if (i_Rst) begin
      h_cnt_reg      <= '0;
      v_cnt_reg      <= '0;
      hsync_reg      <= SYNC_OFF;
      vsync_reg      <= SYNC_OFF;
      active_reg     <= 1'b0;
      line_start_reg <= 1'b0;
      last_px_reg    <= 1'b0;
      frame_end_reg  <= 1'b0;
    end else begin
      h_cnt_reg      <= h_cnt_next;
      v_cnt_reg      <= v_cnt_next;
      hsync_reg      <= (h_cnt_reg < H_SYNC_END) ? SYNC_ON : SYNC_OFF;
      vsync_reg      <= (v_cnt_reg < V_SYNC_END) ? SYNC_ON : SYNC_OFF;
      active_reg     <= active;
      line_start_reg <= h_first && v_act;
      last_px_reg    <= h_last && v_last;
      // One cycle behind the last visible pixel, so it lands on the first
      // blank position even when the front porch is zero wide.
      frame_end_reg  <= last_px_reg;
    end
  end

`ifdef VGA_TILE_TIMING_FRAME_CNT_EN
  logic [FRAME_CNT_W-1:0] frame_count_reg;

  // Steps on the same edge that raises o_frame_end.
  always_ff @(posedge i_Clk or posedge i_Rst) begin
    if (i_Rst) begin
      frame_count_reg <= '0;
    end else if (last_px_reg) begin
      frame_count_reg <= frame_count_reg + FRAME_CNT_W'(1);
    end
  end

  assign o_frame_count = frame_count_reg;
`endif

  assign o_VGA_HSync  = hsync_reg;
  assign o_VGA_VSync  = vsync_reg;
  assign o_active     = active_reg;
  assign o_line_start = line_start_reg;
  assign o_frame_end  = frame_end_reg;
  assign o_pixel_x    = axis_pixel[AXIS_H];
  assign o_pixel_y    = axis_pixel[AXIS_V];
  assign o_tile_col   = axis_tile[AXIS_H];
  assign o_tile_row   = axis_tile[AXIS_V];
  assign o_tile_off_x = axis_offset[AXIS_H];
  assign o_tile_off_y = axis_offset[AXIS_V];

endmodule

// File: tb/tb_vga_tile_timing.sv
// ---------------------------------------------------------------------------
// tb_vga_tile_timing
//
// Small raster (32 x 17 cycles, 20 x 10 visible) with tiles that do not
// divide the display (6 x 4), so partial last tiles appear on both axes.
// The stimulus process drives i_Rst (fixed phases plus random reset
// episodes) and pushes the expected outputs for the next clock edge into
// a queue; the monitor pops and compares after every edge. Expectations
// come from plain position arithmetic (div/mod of cycles since release).
// ---------------------------------------------------------------------------
module tb_vga_tile_timing;

  localparam int HD = 20, HF = 3, HS = 4, HB = 5;
  localparam int VD = 10, VF = 2, VS = 2, VB = 3;
  localparam int TW = 6, TH = 4;
  localparam int CW = 10;
  localparam int FW = 2;
  localparam bit SAL = 1'b1;

  localparam int HT = HD + HF + HS + HB;   // 32
  localparam int VT = VD + VF + VS + VB;   // 17
  localparam int FT = HT * VT;             // 544
  localparam int HA = HS + HB;             // first visible column
  localparam int VA = VS + VB;             // first visible line

  typedef struct packed {
    logic          hs;
    logic          vs;
    logic          act;
    logic          ls;
    logic          fe;
    logic [CW-1:0] px;
    logic [CW-1:0] py;
    logic [CW-1:0] tc;
    logic [CW-1:0] tr;
    logic [CW-1:0] ox;
    logic [CW-1:0] oy;
    logic [FW-1:0] fc;
  } out_t;

  logic          i_Clk;
  logic          i_Rst;
  logic          o_VGA_HSync, o_VGA_VSync, o_active, o_line_start, o_frame_end;
  logic [CW-1:0] o_pixel_x, o_pixel_y, o_tile_col, o_tile_row;
  logic [CW-1:0] o_tile_off_x, o_tile_off_y;
`ifdef VGA_TILE_TIMING_FRAME_CNT_EN
  logic [FW-1:0] o_frame_count;
`endif

  vga_tile_timing #(
    .H_DISPLAY(HD), .H_FRONT(HF), .H_SYNC(HS), .H_BACK(HB),
    .V_DISPLAY(VD), .V_FRONT(VF), .V_SYNC(VS), .V_BACK(VB),
    .TILE_W(TW), .TILE_H(TH), .SYNC_ACTIVE_LOW(SAL), .COORD_W(CW)
`ifdef VGA_TILE_TIMING_FRAME_CNT_EN
    , .FRAME_CNT_W(FW)
`endif
  ) dut (
    .i_Clk        (i_Clk),
    .i_Rst        (i_Rst),
    .o_VGA_HSync  (o_VGA_HSync),
    .o_VGA_VSync  (o_VGA_VSync),
    .o_active     (o_active),
    .o_pixel_x    (o_pixel_x),
    .o_pixel_y    (o_pixel_y),
    .o_tile_col   (o_tile_col),
    .o_tile_row   (o_tile_row),
    .o_tile_off_x (o_tile_off_x),
    .o_tile_off_y (o_tile_off_y),
    .o_line_start (o_line_start),
    .o_frame_end  (o_frame_end)
`ifdef VGA_TILE_TIMING_FRAME_CNT_EN
    , .o_frame_count(o_frame_count)
`endif
  );

  initial i_Clk = 1'b0;
  always #5 i_Clk = ~i_Clk;

  out_t exp_q[$];
  int   checks = 0;
  int   errors = 0;
  bit   done   = 1'b0;

  // Model state: k = clock edges since reset release, fc = frame ends seen.
  int k  = 0;
  int fc = 0;
  bit rst_prev = 1'b1;

  function automatic string fmt(input out_t o);
    return $sformatf("hs=%b vs=%b act=%b px=%0d py=%0d col=%0d row=%0d ox=%0d oy=%0d ls=%b fe=%b fc=%0d",
                     o.hs, o.vs, o.act, o.px, o.py, o.tc, o.tr, o.ox, o.oy,
                     o.ls, o.fe, o.fc);
  endfunction

  function automatic out_t reset_value();
    out_t e;
    e    = '0;
    e.hs = SAL;        // deasserted level
    e.vs = SAL;
    return e;
  endfunction

  function automatic bit is_last_visible(input int pos);
    int p;
    p = pos % FT;
    return ((p % HT) == HA + HD - 1) && ((p / HT) == VA + VD - 1);
  endfunction

  // Outputs for raster position pos (cycles since release), straight from
  // the raster definition.
  function automatic out_t position_value(input int pos);
    out_t e;
    int p, h, v, x, y;
    p    = pos % FT;
    h    = p % HT;
    v    = p / HT;
    e    = '0;
    e.hs = (h < HS) ? !SAL : SAL;
    e.vs = (v < VS) ? !SAL : SAL;
    if (h >= HA && h < HA + HD && v >= VA && v < VA + VD) begin
      x     = h - HA;
      y     = v - VA;
      e.act = 1'b1;
      e.px  = CW'(x);
      e.py  = CW'(y);
      e.tc  = CW'(x / TW);
      e.ox  = CW'(x % TW);
      e.tr  = CW'(y / TH);
      e.oy  = CW'(y % TH);
      e.ls  = (x == 0);
    end
    return e;
  endfunction

  function automatic out_t sample_dut();
    out_t a;
    a.hs  = o_VGA_HSync;
    a.vs  = o_VGA_VSync;
    a.act = o_active;
    a.ls  = o_line_start;
    a.fe  = o_frame_end;
    a.px  = o_pixel_x;
    a.py  = o_pixel_y;
    a.tc  = o_tile_col;
    a.tr  = o_tile_row;
    a.ox  = o_tile_off_x;
    a.oy  = o_tile_off_y;
`ifdef VGA_TILE_TIMING_FRAME_CNT_EN
    a.fc  = o_frame_count;
`else
    a.fc  = '0;
`endif
    return a;
  endfunction

  // One cycle of stimulus: drive reset at the falling edge and queue what
  // the next rising edge must produce.
  task automatic step_cycle(input bit rst);
    out_t e, a;
    @(negedge i_Clk);
    i_Rst = rst;
    if (rst) begin
      exp_q.push_back(reset_value());
      k  = 0;
      fc = 0;
      if (!rst_prev) begin
        // Asynchronous assertion: outputs must drop without a clock edge.
        #1;
        a = sample_dut();
        checks++;
        if (a !== reset_value()) begin
          errors++;
          $display("FAIL async_reset got {%s} required {%s}", fmt(a), fmt(reset_value()));
        end
      end
    end else begin
      e = position_value(k);
      if (k >= 1 && is_last_visible(k - 1)) begin
        e.fe = 1'b1;
        fc++;
      end
`ifdef VGA_TILE_TIMING_FRAME_CNT_EN
      e.fc = FW'(fc % (1 << FW));
`endif
      exp_q.push_back(e);
      k++;
    end
    rst_prev = rst;
  endtask

  // Monitor: every rising edge presents one output vector.
  initial begin : monitor
    out_t e, a;
    forever begin
      @(posedge i_Clk);
      #1;
      if (done) break;
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL scoreboard_empty at t=%0t got {%s} required an expected entry",
                 $time, fmt(sample_dut()));
      end else begin
        e = exp_q.pop_front();
        a = sample_dut();
        if (a !== e) begin
          errors++;
          $display("FAIL outputs t=%0t got {%s} required {%s}", $time, fmt(a), fmt(e));
        end
      end
    end
  end

  initial begin : stimulus
    int n, r, target, guard;
    i_Rst = 1'b1;
    exp_q.push_back(reset_value());

    repeat (3) step_cycle(1'b1);
    $display("phase reset: 3 cycles held in reset");

    n = 5 * FT + 10;
    repeat (n) step_cycle(1'b0);
    $display("phase frames: %0d cycles free-running (5 frames, frame counter wraps)", n);

    // Reset while a mid-frame visible pixel is on the outputs.
    target = (VA + 4) * HT + (HA + 7);
    guard  = 0;
    while ((k % FT) != target + 1 && guard < 2 * FT) begin
      step_cycle(1'b0);
      guard++;
    end
    checks++;
    if ((k % FT) != target + 1) begin
      errors++;
      $display("FAIL reach_target got pos=%0d required %0d", k % FT, target + 1);
    end
    repeat (2) step_cycle(1'b1);
    repeat (2 * HT) step_cycle(1'b0);
    $display("phase targeted: reset at visible pixel x=7 y=4 after %0d cycles", guard);

    for (int ep = 0; ep < 25; ep++) begin
      n = $urandom_range(1, 3 * FT);
      r = $urandom_range(1, 3);
      repeat (n) step_cycle(1'b0);
      repeat (r) step_cycle(1'b1);
      $display("episode %0d: ran %0d cycles then reset %0d cycles", ep, n, r);
    end

    n = 2 * FT;
    repeat (n) step_cycle(1'b0);
    $display("phase tail: %0d cycles free-running", n);

    @(posedge i_Clk);
    #2;
    done = 1'b1;
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL scoreboard_leftover got %0d entries required 0", exp_q.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures", checks, errors);
    $finish;
  end

endmodule

// File: doc/vga_tile_timing.md
# vga_tile_timing

Parametrised VGA raster generator for the game display path: produces horizontal/vertical sync, an active-video flag, pixel coordinates, and tile-grid coordinates (column, row, offset inside tile) for arbitrary resolution, porch widths and tile size. It sits between the pixel clock and the sprite/colour logic, which consumes tile coordinates directly without any multiply or divide. It also emits per-line and per-frame strobes so game state can be updated safely during blanking.

## Interface
- H_DISPLAY, 640, active pixels per line
- H_FRONT, 18, horizontal front porch (cycles)
- H_SYNC, 92, horizontal sync width (cycles)
- H_BACK, 50, horizontal back porch (cycles)
- V_DISPLAY, 480, active lines per frame
- V_FRONT, 10, vertical front porch (lines)
- V_SYNC, 2, vertical sync width (lines)
- V_BACK, 33, vertical back porch (lines)
- TILE_W, 32, tile width in pixels (≥1)
- TILE_H, 32, tile height in pixels (≥1)
- SYNC_ACTIVE_LOW, 1, 1 = sync pulses driven low, 0 = driven high
- COORD_W, 10, width of all coordinate outputs
- FRAME_CNT_W, 8, width of o_frame_count (only with the macro)

Ports:
- i_Clk  in  1  pixel clock; one pixel per cycle
- i_Rst  in  1  reset; asynchronous, active-high
- o_VGA_HSync  out  1  horizontal sync
- o_VGA_VSync  out  1  vertical sync
- o_active  out  1  high during visible pixels
- o_pixel_x / o_pixel_y  out  COORD_W  visible pixel coordinate
- o_tile_col / o_tile_row  out  COORD_W  tile index
- o_tile_off_x / o_tile_off_y  out  COORD_W  offset inside current tile
- o_line_start  out  1  one-cycle strobe on first active pixel of each visible line
- o_frame_end  out  1  one-cycle strobe immediately after last active pixel of a frame
- o_frame_count  out  FRAME_CNT_W  completed-frame counter (macro only)

## Operation
- Line order: sync, back porch, display, front porch; H_TOTAL = sum of four H params; same order vertically, V_TOTAL likewise.
- Internal h_cnt 0..H_TOTAL-1, v_cnt 0..V_TOTAL-1; h wraps to 0 and advances v; v wraps at V_TOTAL-1.
- Active when h_cnt in [H_SYNC+H_BACK, H_SYNC+H_BACK+H_DISPLAY) and v_cnt in the equivalent vertical window.
- pixel_x / pixel_y: 0 at first active pixel/line, increment per active pixel/line.
- Tile counters are incremental: off_x increments each active pixel; on reaching TILE_W-1 it returns to 0 and tile_col increments. Both clear at the first active pixel of each line. Vertical counters are identical, advancing once per visible line on the line's last active pixel.
- Partial last tile (display not a multiple of tile size): last column index = ceil(H_DISPLAY/TILE_W)-1 with offset stopping below TILE_W; no wrap-around into the next line.
- When o_active=0, all coordinate and tile outputs are 0.
- Sync level: asserted value = ~SYNC_ACTIVE_LOW while h_cnt < H_SYNC (resp. v_cnt < V_SYNC).

## Timing
- All outputs registered; one-cycle latency from internal counters, all outputs mutually aligned.
- Reset (asynchronous assert, synchronous release): h_cnt=v_cnt=0, all tile and coordinate state 0, o_active=0, strobes 0, syncs at deasserted level, o_frame_count=0. Sync asserts on the first clock after release.
- Reset mid-line or mid-frame: restarts at h=0, v=0; no strobe is generated by reset.
- o_frame_end and o_line_start never coincide; each is exactly one cycle wide.

## Configuration
- VGA_TILE_TIMING_FRAME_CNT_EN defined: o_frame_count exists and increments (wrapping at 2^FRAME_CNT_W) in the same cycle o_frame_end is high.
- Undefined: port and counter are absent; all other behaviour is unchanged.

## Structure
- Shared package holds the default 640x480 timing constants, the H_TOTAL/V_TOTAL derivations, and the sync polarity constant for reuse by the top level and sprite modules.
- One natural sub-module: tile_axis_counter (pixel, tile index, offset for a single axis), instantiated once for horizontal and once for vertical.

## Test plan
- Defaults, run 2 lines -> HSync low for 92 cycles, period 800; o_active first high 143 cycles after line start and stays high for 640 cycles.
- Defaults, full frame -> VSync low 2 lines; 480 active lines; o_frame_end once every 420000 cycles.
- Defaults, at pixel_x=31,32 -> tile_col 0→1, off_x 31→0; pixel_x=639 -> tile_col 19; pixel_y=479 -> tile_row 14.
- TILE_W=48 -> last tile_col 13, off_x runs 0..15, then active drops and counters return to 0.
- Assert i_Rst at pixel (300,200) -> outputs go to reset values immediately; after release, sync asserts next cycle and no spurious strobe occurs.
- With the macro, 3 frames -> o_frame_count 0→1→2→3, each step coinciding with o_frame_end; FRAME_CNT_W=2 wraps 3→0.
